// File: rtl/l2_arbiter.sv
// l2_arbiter: serialises I-cache and D-cache line transactions onto one shared L2 port.
// Define L2_ARB_ROUND_ROBIN_EN for round-robin tie-breaking; otherwise the D-cache wins ties.
module l2_arbiter #(
  parameter int LINE_W = 256,
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] i_address,
  input  logic              i_read,
  output logic [LINE_W-1:0] i_rdata,
  output logic              i_resp,
  input  logic [ADDR_W-1:0] d_address,
  input  logic              d_read,
  input  logic              d_write,
  input  logic [LINE_W-1:0] d_wdata,
  output logic [LINE_W-1:0] d_rdata,
  output logic              d_resp,
  output logic [ADDR_W-1:0] l2_address,
  output logic              l2_read,
  output logic              l2_write,
  output logic [LINE_W-1:0] l2_wdata,
  input  logic [LINE_W-1:0] l2_rdata,
  input  logic              l2_resp
);
  typedef enum logic [1:0] {IDLE, SERVE_I, SERVE_D, RELEASE} state_t;
  state_t            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [LINE_W-1:0] wdata_q, wdata_d;
  logic              wr_q, wr_d;
  logic              i_req, d_req, grant_d, serving;
  assign i_req = i_read;
  assign d_req = d_read | d_write;
`ifdef L2_ARB_ROUND_ROBIN_EN
  logic last_i_q, last_i_d;
  assign grant_d  = d_req & (~i_req | last_i_q);
  assign last_i_d = (state_q == IDLE && (i_req || d_req)) ? ~grant_d : last_i_q;
  always_ff @(posedge clk or posedge rst)
    if (rst) last_i_q <= 1'b1;
    else     last_i_q <= last_i_d;
`else
  assign grant_d = d_req;
`endif
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      addr_q  <= '0;
      wdata_q <= '0;
      wr_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      wr_q    <= wr_d;
    end
  end
  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    wr_d    = wr_q;
    case (state_q)
      IDLE:
        if (grant_d) begin
          state_d = SERVE_D;
          addr_d  = d_address;
          wdata_d = d_wdata;
          wr_d    = d_write;
        end else if (i_req) begin
          state_d = SERVE_I;
          addr_d  = i_address;
          wr_d    = 1'b0;
        end
      SERVE_I, SERVE_D: state_d = l2_resp ? RELEASE : state_q;
      default:          state_d = IDLE;
    endcase
  end
  assign serving    = (state_q == SERVE_I) || (state_q == SERVE_D);
  assign l2_read    = serving & ~wr_q;
  assign l2_write   = serving & wr_q;
  assign l2_address = addr_q;
  assign l2_wdata   = wdata_q;
  assign i_resp     = (state_q == SERVE_I) & l2_resp;
  assign d_resp     = (state_q == SERVE_D) & l2_resp;
  assign i_rdata    = l2_rdata;
  assign d_rdata    = l2_rdata;
endmodule

// File: tb/tb_l2_arbiter.sv
// tb_l2_arbiter: directed and randomized checks of l2_arbiter against a transaction-level model.
module tb_l2_arbiter;
  localparam int LW = 256;
  localparam int AW = 32;
  logic          clk = 1'b0, rst = 1'b1;
  logic [AW-1:0] i_address = '0, d_address = '0, l2_address;
  logic          i_read = 1'b0, d_read = 1'b0, d_write = 1'b0, l2_resp = 1'b0;
  logic          i_resp, d_resp, l2_read, l2_write;
  logic [LW-1:0] d_wdata = '0, l2_rdata = '0, i_rdata, d_rdata, l2_wdata, pat = '0;
  int            n_tests = 0, n_fail = 0, n_i = 0, n_d = 0, lat = 1;
  bit            rand_lat = 1'b0, spurious = 1'b0, use_pat = 1'b0;
  string         glog = "";

  always #5 clk = ~clk;

  l2_arbiter dut (
    .clk(clk), .rst(rst),
    .i_address(i_address), .i_read(i_read), .i_rdata(i_rdata), .i_resp(i_resp),
    .d_address(d_address), .d_read(d_read), .d_write(d_write), .d_wdata(d_wdata),
    .d_rdata(d_rdata), .d_resp(d_resp),
    .l2_address(l2_address), .l2_read(l2_read), .l2_write(l2_write), .l2_wdata(l2_wdata),
    .l2_rdata(l2_rdata), .l2_resp(l2_resp)
  );

  task automatic check(input string name, input logic [LW-1:0] act, input logic [LW-1:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; i_read = 1'b0; d_read = 1'b0; d_write = 1'b0;
    rand_lat = 1'b0; spurious = 1'b0; use_pat = 1'b0;
    @(negedge clk);
    check("rst_l2_address", LW'(l2_address), '0);
    check("rst_l2_wdata", l2_wdata, '0);
    cyc(1);
    rst = 1'b0; n_i = 0; n_d = 0; glog = "";
    cyc(1);
  endtask

  task automatic wait_resp(output int k, output bit seen);
    k = 1; seen = 1'b0;
    while (!seen && k < 40) begin
      if (i_resp || d_resp) seen = 1'b1;
      else begin
        @(negedge clk);
        k++;
      end
    end
  endtask

  // L2 model: answers after a chosen latency counted from the first request cycle
  initial begin
    int cnt, cur;
    cnt = 0; cur = 1;
    forever begin
      @(posedge clk);
      #1;
      if (rst || !(l2_read || l2_write)) begin
        cnt = 0;
        l2_resp = spurious && ($urandom_range(3) == 0);
      end else begin
        cnt++;
        if (cnt == 1) cur = rand_lat ? int'($urandom_range(4, 1)) : lat;
        l2_resp = cnt >= cur;
      end
      for (int k = 0; k < LW / 32; k++) l2_rdata[k*32 +: 32] = use_pat ? pat[k*32 +: 32] : $urandom;
    end
  end

  // Transaction-level reference: owner of the port, one release cycle, latched request
  initial begin
    int            own;
    bit            rel, wr, last_i, ir, dr, pick_d;
    logic [AW-1:0] a;
    logic [LW-1:0] w;
    own = 0; rel = 0; wr = 0; last_i = 1; a = '0; w = '0;
    forever begin
      @(negedge clk);
      if (rst) begin
        own = 0; rel = 0; wr = 0; last_i = 1; a = '0; w = '0;
        check("rst_l2_read", LW'(l2_read), '0);
        check("rst_l2_write", LW'(l2_write), '0);
        check("rst_i_resp", LW'(i_resp), '0);
        check("rst_d_resp", LW'(d_resp), '0);
      end else begin
        check("l2_read", LW'(l2_read), LW'(own != 0 && !wr));
        check("l2_write", LW'(l2_write), LW'(own != 0 && wr));
        if (own != 0) check("l2_address", LW'(l2_address), LW'(a));
        if (own != 0 && wr) check("l2_wdata", l2_wdata, w);
        check("i_resp", LW'(i_resp), LW'(own == 1 && l2_resp));
        check("d_resp", LW'(d_resp), LW'(own == 2 && l2_resp));
        if (i_resp) begin check("i_rdata", i_rdata, l2_rdata); n_i++; glog = {glog, "I"}; end
        if (d_resp) begin check("d_rdata", d_rdata, l2_rdata); n_d++; glog = {glog, "D"}; end
        if (own != 0 && l2_resp) begin
          own = 0; rel = 1;
        end else if (rel) rel = 0;
        else if (own == 0) begin
          ir = i_read;
          dr = d_read || d_write;
`ifdef L2_ARB_ROUND_ROBIN_EN
          pick_d = dr && (!ir || last_i);
`else
          pick_d = dr;
`endif
          if (pick_d) begin
            own = 2; a = d_address; w = d_wdata; wr = d_write; last_i = 0;
          end else if (ir) begin
            own = 1; a = i_address; wr = 0; last_i = 1;
          end
        end
      end
    end
  end

  initial begin
    logic [LW-1:0] pa, pb;
    int            k;
    bit            seen;
    string         exp_order;
    pa = {8{32'hA5A5_0F0F}};
    pb = {8{32'hDEAD_BEEF}};
    cyc(1);
    do_reset();

    lat = 5; use_pat = 1'b1; pat = pa;
    i_address = 32'h0000_1000; i_read = 1'b1;
    cyc(1);
    @(negedge clk);
    check("t1_l2_read", LW'(l2_read), LW'(1));
    check("t1_l2_address", LW'(l2_address), LW'(32'h0000_1000));
    wait_resp(k, seen);
    check("t1_resp_seen", LW'(seen), LW'(1));
    check("t1_resp_cycle", LW'(k), LW'(5));
    check("t1_i_rdata", i_rdata, pa);
    check("t1_d_resp", LW'(d_resp), '0);
    cyc(1);
    i_read = 1'b0;
    cyc(3);
    check("t1_i_count", LW'(n_i), LW'(1));
    check("t1_d_count", LW'(n_d), '0);

    do_reset();
    lat = 4;
    d_address = 32'h8000_0040; d_wdata = pb; d_write = 1'b1;
    cyc(1);
    @(negedge clk);
    check("t2_l2_write", LW'(l2_write), LW'(1));
    check("t2_l2_wdata", l2_wdata, pb);
    wait_resp(k, seen);
    check("t2_resp_seen", LW'(seen), LW'(1));
    check("t2_wdata_at_resp", l2_wdata, pb);
    check("t2_write_at_resp", LW'(l2_write), LW'(1));
    cyc(1);
    d_write = 1'b0;
    cyc(3);
    check("t2_d_count", LW'(n_d), LW'(1));

    do_reset();
    lat = 2;
    i_address = 32'h0000_2000; d_address = 32'h0000_3000;
    i_read = 1'b1; d_read = 1'b1;
    for (int c = 0; c < 80 && n_i + n_d < 3; c++) @(negedge clk);
    cyc(1);
    i_read = 1'b0; d_read = 1'b0;
    cyc(3);
`ifdef L2_ARB_ROUND_ROBIN_EN
    exp_order = "DID";
`else
    exp_order = "DDD";
`endif
    n_tests++;
    if (glog != exp_order) begin
      n_fail++;
      $display("FAIL t3_grant_order: got %s expected %s", glog, exp_order);
    end

    do_reset();
    lat = 6;
    d_address = 32'h4000_0100; d_read = 1'b1;
    cyc(3);
    d_read = 1'b0; d_address = 32'h1234_5678;
    @(negedge clk);
    wait_resp(k, seen);
    check("t5_resp_seen", LW'(seen), LW'(1));
    check("t5_d_resp", LW'(d_resp), LW'(1));
    check("t5_l2_read_held", LW'(l2_read), LW'(1));
    check("t5_addr_held", LW'(l2_address), LW'(32'h4000_0100));
    @(negedge clk);
    check("t5_release_idle", LW'(l2_read), '0);

    do_reset();
    lat = 5;
    i_address = 32'h0000_2000; i_read = 1'b1;
    cyc(2);
    rst = 1'b1; i_read = 1'b0;
    #1;
    check("t6_read_drop", LW'(l2_read), '0);
    check("t6_no_i_resp", LW'(i_resp), '0);
    cyc(1);
    rst = 1'b0; i_address = 32'h0000_3000; i_read = 1'b1;
    cyc(1);
    @(negedge clk);
    check("t6_fresh_read", LW'(l2_read), LW'(1));
    check("t6_fresh_addr", LW'(l2_address), LW'(32'h0000_3000));
    wait_resp(k, seen);
    check("t6_resp_seen", LW'(seen), LW'(1));
    cyc(1);
    i_read = 1'b0;
    cyc(2);
    check("t6_i_count", LW'(n_i), LW'(1));

    do_reset();
    rand_lat = 1'b1; spurious = 1'b1;
    for (int c = 0; c < 3000; c++) begin
      int r;
      r = int'($urandom_range(9));
      i_read = $urandom_range(2) != 0;
      d_read = r < 4 || r == 9;
      d_write = r >= 6;
      i_address = $urandom; d_address = $urandom;
      for (int j = 0; j < LW / 32; j++) d_wdata[j*32 +: 32] = $urandom;
      cyc(1);
    end
    i_read = 1'b0; d_read = 1'b0; d_write = 1'b0;
    cyc(6);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/l2_arbiter.md
# l2_arbiter

Two-requester arbiter that shares the single unified L2 cache port between the instruction-cache and data-cache miss paths. It sits between the two L1 cache controllers' physical-memory ports and the L2 cache controller's CPU-side port. It serialises whole-line transactions, latches the winner's address and write data, and routes the L2 response back to that winner only.

## Interface
Parameters:
- LINE_W, 256, cache line width in bits
- ADDR_W, 32, address width

Ports:
- clk  in  1  clock; all state updates on posedge
- rst  in  1  asynchronous reset, active-high
- i_address  in  ADDR_W  I-cache line address
- i_read  in  1  I-cache line read request (I-side never writes)
- i_rdata  out  LINE_W  line returned to I-cache
- i_resp  out  1  I-cache transaction complete
- d_address  in  ADDR_W  D-cache line address
- d_read  in  1  D-cache line read request
- d_write  in  1  D-cache line write-back request
- d_wdata  in  LINE_W  D-cache write-back data
- d_rdata  out  LINE_W  line returned to D-cache
- d_resp  out  1  D-cache transaction complete
- l2_address  out  ADDR_W  address to L2
- l2_read  out  1  L2 read
- l2_write  out  1  L2 write
- l2_wdata  out  LINE_W  write data to L2
- l2_rdata  in  LINE_W  line from L2
- l2_resp  in  1  L2 transaction complete

## Operation
- States: IDLE, SERVE_I, SERVE_D, RELEASE.
- IDLE: no L2 request driven. Evaluates i_req = i_read and d_req = d_read | d_write.
  - Only i_req: latch i_address into the address register, then go to SERVE_I.
  - Only d_req: latch d_address, d_wdata and d_write into the address, data and write-flag registers, then go to SERVE_D.
  - Both: winner is chosen per Configuration.
- SERVE_I and SERVE_D:
  - l2_read or l2_write is driven from the latched flag. l2_address and l2_wdata come from the latched registers.
  - Requester inputs are ignored; a requester deasserting mid-service does not abort the transaction.
  - On l2_resp: pulse the winner's *_resp in the same cycle, then go to RELEASE.
- RELEASE: one dead cycle with no L2 request. This lets the served L1 drop its request before the next arbitration. Then go to IDLE.
- d_read and d_write asserted together is illegal. In that case write takes priority.
- i_rdata and d_rdata are both wired combinationally to l2_rdata. They are valid only while the matching *_resp is high.
- l2_resp outside SERVE_I or SERVE_D is ignored; no *_resp is generated.

## Timing
- Reset values:
  - state IDLE
  - l2_read, l2_write, i_resp, d_resp all 0
  - l2_address and l2_wdata 0
  - last-grant flag = I
- Request seen in IDLE at cycle 0; L2 request appears at cycle 1 and is held stable until l2_resp.
- Response latency: *_resp is asserted in the same cycle as l2_resp (combinational pass-through). *_resp is never asserted without l2_resp.
- After l2_resp at cycle N, the state is RELEASE at N+1 and IDLE at N+2. The earliest next L2 request is N+3.
- A zero-wait L2 (l2_resp in the first SERVE cycle) still completes correctly.
- Reset asserted mid-transaction immediately drops l2_read/l2_write and returns to IDLE; the L2 is reset by the same rst.

## Configuration
- L2_ARB_ROUND_ROBIN_EN defined:
  - On simultaneous requests, the requester not granted last wins.
  - The last-grant flag updates on every grant.
- Undefined:
  - Fixed priority, D-cache wins all ties.
  - The last-grant flag is not implemented.

## Test plan
- I-only: i_read=1 with i_address=0x0000_1000, and L2 responds after 5 cycles with rdata=pattern A. Required: l2_read=1 with l2_address=0x0000_1000 from cycle 1; i_resp=1 and i_rdata=A in the l2_resp cycle; d_resp stays 0.
- D write-back: d_write=1, d_address=0x8000_0040, d_wdata=pattern B. Required: l2_write=1 and l2_wdata=B held until l2_resp; d_resp pulses once.
- Simultaneous i_read and d_read, held across three back-to-back transactions, with the macro undefined. Required: grant order D, D, D, and i_resp never asserts.
- Same stimulus with L2_ARB_ROUND_ROBIN_EN defined. Required: grant order D, I, D; the first grant goes to D because the reset last-grant flag is I.
- Requester drops d_read two cycles into SERVE_D. Required: l2_read and l2_address are held until l2_resp; d_resp still pulses; the state then passes through RELEASE to IDLE.
- rst pulsed during SERVE_I. Required: l2_read=0 in the same cycle; no i_resp; after reset, a fresh i_read is served normally.
